// File: rtl/disp_pkg.sv
// disp_pkg: shared types, constants and helpers for the display scan controller.
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEG_W_DEFAULT = 7;
  typedef logic [1:0] digit_idx_t;
  typedef logic [SEG_W_DEFAULT-1:0] seg_t;
  localparam seg_t SEG_BLANK = '0;
  typedef enum logic {ST_IDLE, ST_PENDING} commit_state_t;
  function automatic logic [NUM_DIGITS-1:0] onehot4(input digit_idx_t i);
    return 4'(1) << i;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-digit dwell counter, digit index and PWM lit window.
module scan_prescaler import disp_pkg::*; #(
  parameter int DIV_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] bright,
  output logic       tick,
  output digit_idx_t idx,
  output logic       lit
);
  logic [DIV_WIDTH-1:0] r_cnt;
  digit_idx_t           r_idx;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= en ? r_cnt + 1'b1 : '0;
      r_idx <= en ? r_idx + digit_idx_t'(tick) : '0;
    end

  // brightness compares against the top three bits, so each step is 1/8 of the dwell
  assign tick = en && (&r_cnt);
  assign lit  = en && (r_cnt[DIV_WIDTH-1 -: 3] <= bright);
  assign idx  = r_idx;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexed 4-digit 7-segment driver with staged,
// frame-aligned pattern commits and PWM brightness.
module display_scan_controller import disp_pkg::*; #(
  parameter int DIV_WIDTH = 3,
  parameter int SEG_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_digit,
  input  logic [SEG_W-1:0] wr_value,
  input  logic             commit,
  output logic             commit_pending,
  input  logic [2:0]       bright,
  output logic             frame_done,
  output logic [3:0]       digit_sel,
  output logic [SEG_W-1:0] seg_out
);
  logic             w_tick, w_lit, w_frame_end, w_apply, w_wr_fire;
  digit_idx_t       w_idx;
  commit_state_t    r_state, w_next;
  logic [SEG_W-1:0] r_stage [NUM_DIGITS];
  logic [SEG_W-1:0] r_active [NUM_DIGITS];
  logic             r_wr_ready, r_frame_done;
  logic [3:0]       r_digit_sel;
  logic [SEG_W-1:0] r_seg;

  scan_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_pre (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .bright (bright),
    .tick   (w_tick),
    .idx    (w_idx),
    .lit    (w_lit)
  );

  assign w_frame_end = w_tick && (w_idx == 2'd3);
  assign w_wr_fire   = wr_valid && r_wr_ready;

  // with the scan stopped there is no frame to tear, so publish right away
  always_comb begin
    w_apply = (r_state == ST_PENDING) && (!en || w_frame_end);
    w_next  = w_apply ? ST_IDLE : (commit ? ST_PENDING : r_state);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_stage[k]  <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (w_wr_fire) r_stage[wr_digit] <= wr_value;
      if (w_apply) r_active <= r_stage;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ready   <= 1'b0;
      r_frame_done <= 1'b0;
      r_digit_sel  <= '0;
      r_seg        <= '0;
    end else begin
      r_wr_ready   <= (w_next == ST_IDLE);
      r_frame_done <= w_frame_end;
      r_digit_sel  <= w_lit ? onehot4(w_idx) : '0;
      r_seg        <= w_lit ? r_active[w_idx] : '0;
    end

  assign wr_ready       = r_wr_ready;
  assign commit_pending = (r_state == ST_PENDING);
  assign frame_done     = r_frame_done;
  assign digit_sel      = r_digit_sel;
  assign seg_out        = r_seg;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed and random stimulus against a time-based reference model.
module tb_display_scan_controller;
  logic       clk = 0;
  logic       rst = 0;
  logic       en = 0;
  logic       wr_valid = 0;
  logic       wr_ready;
  logic [1:0] wr_digit = 0;
  logic [6:0] wr_value = 0;
  logic       commit = 0;
  logic       commit_pending;
  logic [2:0] bright = 7;
  logic       frame_done;
  logic [3:0] digit_sel;
  logic [6:0] seg_out;

  int passes = 0;
  int total = 0;
  int t = 0;
  bit pend = 0, rdy = 0;
  logic [6:0] stg [4];
  logic [6:0] act [4];

  display_scan_controller #(.DIV_WIDTH(3), .SEG_W(7)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_digit(wr_digit), .wr_value(wr_value), .commit(commit),
    .commit_pending(commit_pending), .bright(bright), .frame_done(frame_done),
    .digit_sel(digit_sel), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic check_all(input logic [3:0] es, input logic [6:0] eseg, input bit efd,
                           input bit epend, input bit erdy);
    check("digit_sel", 32'(digit_sel), 32'(es));
    check("seg_out", 32'(seg_out), 32'(eseg));
    check("frame_done", 32'(frame_done), 32'(efd));
    check("commit_pending", 32'(commit_pending), 32'(epend));
    check("wr_ready", 32'(wr_ready), 32'(erdy));
  endtask

  // t counts enabled cycles since the scan (re)started: phase = t%8, digit = (t/8)%4
  task automatic step();
    int ph, dg;
    bit lit, fe, apply;
    logic [3:0] es;
    logic [6:0] eseg;
    ph = t % 8;
    dg = (t / 8) % 4;
    lit = en && (ph <= int'(bright));
    es = lit ? 4'(1 << dg) : 4'd0;
    eseg = lit ? act[dg] : 7'd0;
    fe = en && ph == 7 && dg == 3;
    apply = pend && (!en || fe);
    if (apply) for (int k = 0; k < 4; k++) act[k] = stg[k];
    if (wr_valid && rdy) stg[wr_digit] = wr_value;
    pend = apply ? 1'b0 : (pend || commit);
    rdy = !pend;
    t = en ? t + 1 : 0;
    @(posedge clk);
    #1;
    check_all(es, eseg, fe, pend, rdy);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    #1;
    check_all(4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    check_all(4'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    rst = 0;
    t = 0; pend = 0; rdy = 0;
    for (int k = 0; k < 4; k++) begin stg[k] = 0; act[k] = 0; end
  endtask

  task automatic write(input logic [1:0] d, input logic [6:0] v);
    wr_valid = 1; wr_digit = d; wr_value = v;
    step();
    wr_valid = 0;
  endtask

  initial begin
    bit acc;
    #2;
    en = 0;
    do_reset(3);
    repeat (4) step();
    write(0, 7'h01); write(1, 7'h02); write(2, 7'h04); write(3, 7'h08);
    commit = 1; step(); commit = 0;
    repeat (3) step();
    en = 1; bright = 7;
    repeat (70) step();
    for (int k = 0; k < 64 && !((t / 8) % 4 == 1 && t % 8 == 2); k++) step();
    write(0, 7'h7F); write(1, 7'h7F); write(2, 7'h7F); write(3, 7'h7F);
    commit = 1; step(); commit = 0;
    repeat (40) step();
    wr_valid = 1; wr_digit = 2; wr_value = 7'h3F; commit = 1;
    step();
    commit = 0; wr_digit = 1; wr_value = 7'h55;
    acc = 0;
    for (int k = 0; k < 80 && !acc; k++) begin acc = rdy; step(); end
    check("stalled_write_accepted", 32'(acc), 32'd1);
    wr_valid = 0;
    repeat (40) step();
    bright = 0; repeat (40) step();
    bright = 3; repeat (40) step();
    bright = 7;
    for (int k = 0; k < 64 && !((t / 8) % 4 == 2 && t % 8 == 3); k++) step();
    en = 0; step();
    repeat (4) step();
    en = 1; repeat (40) step();
    for (int k = 0; k < 300; k++) begin
      en = $urandom_range(0, 9) != 0;
      bright = 3'($urandom_range(0, 7));
      wr_valid = $urandom_range(0, 2) == 0;
      wr_digit = 2'($urandom_range(0, 3));
      wr_value = 7'($urandom_range(0, 127));
      commit = $urandom_range(0, 15) == 0;
      step();
    end
    wr_valid = 0; commit = 0; en = 1; bright = 7;
    repeat (20) step();
    commit = 1; step(); commit = 0;
    check("pending_before_rst", 32'(commit_pending), 32'd1);
    #2;
    do_reset(2);
    repeat (5) step();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes four 7-segment digit patterns onto a shared segment bus and four digit-enable lines, with a fixed per-digit dwell and PWM brightness.
- Writers load patterns into staging registers through a valid/ready handshake. A commit request copies staging into the active set only at a frame boundary, so the display never shows a mix of old and new digits.
- Sits between the system bus/CPU-side logic and display_module-style drive pins.

Parameters:
- DIV_WIDTH, 3, width of the dwell prescaler. Dwell per digit = 2^DIV_WIDTH clk cycles. Must be >= 3.
- SEG_W, 7, segment pattern width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  display enable. 0 blanks the outputs and holds the scan at its start.
- wr_valid  input  1  staging-write request.
- wr_ready  output  1  staging-write accept.
- wr_digit  input  2  digit index 0..3 to write.
- wr_value  input  SEG_W  segment pattern. Bit i = segment i, active-high.
- commit  input  1  single-cycle request to publish staging to active.
- commit_pending  output  1  a commit is latched and not yet applied.
- bright  input  3  brightness 0..7. 7 = full dwell lit.
- frame_done  output  1  one-cycle pulse when digit 3's dwell ends.
- digit_sel  output  4  one-hot digit enable, active-high. Bit k drives digit k.
- seg_out  output  SEG_W  segment pattern for the selected digit.

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, digit index=0.
  - All staging and active patterns = 0.
  - commit_pending=0, frame_done=0, digit_sel=0, seg_out=0, wr_ready=0.
  - First cycle after release: wr_ready=1.
- Prescaler:
  - While en=1, cnt increments every cycle, modulo 2^DIV_WIDTH.
  - tick when cnt = all-ones. On tick, idx advances 0→1→2→3→0.
  - While en=0, cnt and idx are forced to 0.
- PWM:
  - lit = en && (cnt[DIV_WIDTH-1 -: 3] <= bright).
  - bright=7 → lit for the whole dwell. bright=0 → lit for the first 1/8 of the dwell.
- Outputs are registered, one cycle after cnt/idx:
  - digit_sel = lit ? (1<<idx) : 0.
  - seg_out = lit ? active[idx] : 0.
  - When digit_sel=0, seg_out=0.
- Write handshake:
  - wr_ready = !commit_pending.
  - A write is accepted when wr_valid && wr_ready. staging[wr_digit] <= wr_value on that edge.
  - wr_digit/wr_value must be stable while wr_valid=1 and wr_ready=0.
- Commit:
  - commit=1 sets commit_pending on the next edge. commit while pending has no effect.
  - Write and commit in the same cycle: the write is accepted and included in the commit.
  - Apply point, en=1: on the edge where tick && idx==3. active <= staging (all four), commit_pending <= 0. The new frame starts with idx=0 showing new data.
  - Apply point, en=0: on the edge after commit_pending is set.
- frame_done:
  - Registered 1-cycle pulse on the edge where tick && idx==3 (en=1).
  - Coincides with commit_pending falling when a commit applies.
- en falling mid-frame: outputs go to 0 on the next edge, idx/cnt return to 0, staging and active are retained. en rising restarts at digit 0, cnt 0.
- rst mid-frame: immediate return to reset values; a pending commit is discarded.
- Frame length = 4·2^DIV_WIDTH cycles (32 at default).

Decomposition:
- Package disp_pkg:
  - NUM_DIGITS=4.
  - SEG_BLANK='0.
  - typedef digit_idx_t (logic [1:0]).
  - typedef seg_t (logic [SEG_W-1:0]).
  - Function onehot4(digit_idx_t).
- Sub-module scan_prescaler: cnt, tick, idx, lit. Inputs clk, rst, en, bright.
- The top level holds the staging/active register files, commit FSM (IDLE/PENDING) and output registers.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 3 cycles, release, en=0.
  - Required: digit_sel=0, seg_out=0, wr_ready=1, commit_pending=0 throughout.
- Scan order and dwell:
  - Stimulus: write 7'h01/02/04/08 to digits 0..3, commit with en=0, then en=1, bright=7.
  - Required: digit_sel steps 0001→0010→0100→1000 every 8 cycles. seg_out=01/02/04/08 respectively. frame_done pulses every 32 cycles.
- Tear-free commit:
  - Stimulus: mid-frame with idx=1, write 7'h7F to all digits and pulse commit.
  - Required: wr_ready=0 until the frame end. Old patterns are shown through digit 3. 7'h7F appears from the next digit 0. commit_pending falls with frame_done.
- Simultaneous write and commit:
  - Stimulus: wr_valid=1, wr_digit=2, wr_value=7'h3F, commit=1 in the same cycle.
  - Required: after the apply point, digit 2 shows 7'h3F. A second write during pending is stalled with wr_ready=0 until apply.
- Brightness:
  - Stimulus: bright=0, then 3.
  - Required: each digit is lit for 1 of 8 dwell cycles (bright=0) and 4 of 8 (bright=3), at cnt phases 0 and 0..3. seg_out=0 when unlit.
- Enable and reset mid-frame:
  - Stimulus: drop en at idx=2; re-raise after 5 cycles.
  - Required: outputs are 0 the next cycle. Scan restarts at digit 0 with patterns retained.
  - Stimulus: assert rst with commit_pending=1.
  - Required: outputs are 0 asynchronously and pending is cleared.
